// File: rtl/fix2sfp_seq_if.sv
// Start/busy/done handshake and data bus between a requester and the
// fixed-point to sfp converter.
interface fix2sfp_seq_if #(
  parameter int fixWidth    = 21,
  parameter int formatWidth = 9
);
  logic                   start;
  logic [fixWidth-1:0]    fixin;
  logic                   busy;
  logic                   done;
  logic [formatWidth-1:0] sfpout;

  modport master (
    output start, fixin,
    input  busy, done, sfpout
  );

  modport slave (
    input  start, fixin,
    output busy, done, sfpout
  );
endinterface

// File: rtl/fix2sfp_seq.sv
// Sequential converter from 21-bit two's-complement fixed point (10 fraction
// bits) to the 9-bit sfp format. The magnitude is shifted left one bit per
// clock until its leading one reaches the top bit, then rounded to nearest
// even and packed. Too-large values saturate, too-small values flush to zero.
module fix2sfp_seq #(
  parameter int expWidth    = 4,
  parameter int sigWidth    = 4,
  parameter int formatWidth = 1 + expWidth + sigWidth,
  parameter int fixWidth    = 21,
  parameter int fracWidth   = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  fix2sfp_seq_if.slave bus
);

  localparam int bias         = (1 << (expWidth - 1)) - 1;
  localparam int topBit       = fixWidth - 1;
  // Shift count at which the biased exponent would reach zero.
  localparam int flushCnt     = bias + topBit - fracWidth;
  localparam int cntWidth     = $clog2(flushCnt + 1);
  // Two spare bits so exponent overflow past the field is visible.
  localparam int expCalcWidth = expWidth + 2;

  typedef enum logic {IDLE, NORM} state_e;

  state_e                 state_q, state_d;
  logic [fixWidth-1:0]    mag_q, mag_d;
  logic [cntWidth-1:0]    cnt_q, cnt_d;
  logic                   sign_q, sign_d;
  logic                   done_q, done_d;
  logic [formatWidth-1:0] sfpout_q, sfpout_d;

  logic [sigWidth-1:0]     sigRaw;
  logic                    guardBit;
  logic                    stickyBit;
  logic                    roundUp;
  logic [sigWidth:0]       sigSum;
  logic [expCalcWidth-1:0] expBase;
  logic [expCalcWidth-1:0] expFinal;
  logic                    saturate;
  logic [formatWidth-1:0]  packWord;

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mag_q    <= '0;
      cnt_q    <= '0;
      sign_q   <= 1'b0;
      done_q   <= 1'b0;
      sfpout_q <= '0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      cnt_q    <= cnt_d;
      sign_q   <= sign_d;
      done_q   <= done_d;
      sfpout_q <= sfpout_d;
    end
  end

  // Round-to-nearest-even and pack of the normalised magnitude.
  always_comb begin
    sigRaw    = mag_q[topBit-1 -: sigWidth];
    guardBit  = mag_q[topBit-1-sigWidth];
    stickyBit = |mag_q[topBit-2-sigWidth:0];
    roundUp   = guardBit & (stickyBit | sigRaw[0]);
    sigSum    = {1'b0, sigRaw} + (sigWidth+1)'(roundUp);
    expBase   = expCalcWidth'(flushCnt) - expCalcWidth'(cnt_q);
    expFinal  = expBase + expCalcWidth'(sigSum[sigWidth]);
    saturate  = (expFinal >= expCalcWidth'(1 << expWidth));
    if (saturate) begin
      packWord = {sign_q, {expWidth{1'b1}}, {sigWidth{1'b1}}};
    end else begin
      packWord = {sign_q, expFinal[expWidth-1:0], sigSum[sigWidth-1:0]};
    end
  end

  // Next-state logic: accept a request, then normalise one bit per clock.
  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    cnt_d    = cnt_q;
    sign_d   = sign_q;
    done_d   = 1'b0;
    sfpout_d = sfpout_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_d  = bus.fixin[topBit];
          mag_d   = bus.fixin[topBit] ? (~bus.fixin + fixWidth'(1)) : bus.fixin;
          cnt_d   = '0;
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q == '0) begin
          sfpout_d = '0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (cnt_q == cntWidth'(flushCnt)) begin
          sfpout_d = '0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else if (mag_q[topBit]) begin
          sfpout_d = packWord;
          done_d   = 1'b1;
          state_d  = IDLE;
        end else begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q + cntWidth'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs: busy follows the state, done and result are registered.
  always_comb begin
    bus.busy   = (state_q == NORM);
    bus.done   = done_q;
    bus.sfpout = sfpout_q;
  end

endmodule

// File: tb/tb_fix2sfp_seq.sv
// Directed self-checking bench for the fixed-point to sfp converter.
module tb_fix2sfp_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fix2sfp_seq_if #(.fixWidth(21), .formatWidth(9)) bus ();

  fix2sfp_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One full conversion: start pulse, wait for done, check latency, busy
  // duration, result, and that done drops while the result holds.
  task automatic applyStimulus(input string tag, input logic [20:0] fixVal,
                               input logic [8:0] expSfp, input int expLat);
    int lat;
    int busyCycles;
    @(negedge clk);
    bus.start = 1'b1;
    bus.fixin = fixVal;
    @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.fixin  = '0;
    busyCycles = bus.busy ? 1 : 0;
    lat        = 0;
    while (!bus.done && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.busy) busyCycles++;
    end
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " busyCycles"}, busyCycles, expLat);
    checkOutput({tag, " sfpout"}, {23'd0, bus.sfpout}, {23'd0, expSfp});
    checkOutput({tag, " busyAtDone"}, {31'd0, bus.busy}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, " donePulse"}, {31'd0, bus.done}, 32'd0);
    checkOutput({tag, " sfpoutHold"}, {23'd0, bus.sfpout}, {23'd0, expSfp});
  endtask

  initial begin
    int doneCount;
    int doneA;
    int doneB;
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.fixin = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset done", {31'd0, bus.done}, 32'd0);
    checkOutput("reset sfpout", {23'd0, bus.sfpout}, 32'd0);
    rst_n = 1'b1;

    applyStimulus("one",      21'h000400, 9'h070, 11);
    applyStimulus("minus1p5", 21'h1FFA00, 9'h178, 11);
    applyStimulus("v496",     21'h07C000, 9'h0FF, 3);
    applyStimulus("v512sat",  21'h080000, 9'h0FF, 2);
    applyStimulus("negMax",   21'h100000, 9'h1FF, 1);
    applyStimulus("tieEven",  21'h000420, 9'h070, 11);
    applyStimulus("tieOdd",   21'h000460, 9'h072, 11);
    applyStimulus("aboveHalf",21'h000430, 9'h071, 11);
    applyStimulus("carryExp", 21'h0007E0, 9'h080, 11);
    applyStimulus("zero",     21'h000000, 9'h000, 1);
    applyStimulus("flush15",  21'h00000F, 9'h000, 18);
    applyStimulus("flushNeg", 21'h1FFFF1, 9'h000, 18);

    // Start pulsed while busy must be ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.fixin = 21'h000400;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    bus.fixin = 21'h000000;
    @(negedge clk);
    bus.start = 1'b0;
    doneCount = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) doneCount++;
    end
    checkOutput("busyStart doneCount", doneCount, 1);
    checkOutput("busyStart sfpout", {23'd0, bus.sfpout}, 32'h070);

    // Start held high: each conversion captures fixin at its own accept edge.
    doneA = -1;
    doneB = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.fixin = 21'h07C000;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) begin
        if (doneA < 0) begin
          doneA = k;
          checkOutput("heldA sfpout", {23'd0, bus.sfpout}, 32'h0FF);
          bus.fixin = 21'h000400;
        end else begin
          doneB = k;
          checkOutput("heldB sfpout", {23'd0, bus.sfpout}, 32'h070);
          bus.start = 1'b0;
          break;
        end
      end else begin
        bus.fixin = 21'h015555 ^ 21'(k);
      end
      @(posedge clk);
    end
    bus.start = 1'b0;
    checkOutput("heldA latency", doneA, 3);
    checkOutput("heldB latency", doneB, 15);

    // Reset in the middle of a conversion aborts it silently.
    @(negedge clk);
    bus.start = 1'b1;
    bus.fixin = 21'h000400;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midReset busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("midReset done", {31'd0, bus.done}, 32'd0);
    checkOutput("midReset sfpout", {23'd0, bus.sfpout}, 32'd0);
    rst_n     = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) doneCount++;
    end
    checkOutput("midReset noDone", doneCount, 0);
    applyStimulus("afterReset", 21'h000460, 9'h072, 11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fix2sfp_seq.md
Name: fix2sfp_seq

Overview:
Sequential converter from the 21-bit two's-complement fixed-point domain back to the small floating-point (sfp) format. It is the return path after the fixed-point adder, and turns sums into sfp words for storage and the next butterfly stage. Normalisation is iterative, one bit per clock, using a leading-one search by left shift. Rounding is round-to-nearest-even, overflow saturates, and underflow flushes to zero. A start/busy/done handshake carries one conversion at a time.

Parameters:
expWidth, 4, sfp exponent field width; bias = 2^(expWidth-1)-1 = 7
sigWidth, 4, sfp stored fraction width (hidden leading 1)
formatWidth, 9, sfp word width = 1+expWidth+sigWidth
fixWidth, 21, fixed-point input width, two's complement
fracWidth, 10, fractional bits of the fixed-point input (value = fixin * 2^-10)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only when busy=0
fixin  input  21  fixed-point operand, captured on the accepted start edge
busy  output  1  high while a conversion is in flight
done  output  1  one-cycle pulse; sfpout is valid from that cycle onward
sfpout  output  9  {sign, exp[3:0], sig[3:0]}; exp=0 means zero; no inf/NaN

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, busy=0, done=0, sfpout=0, internal mag/cnt/sign=0. Reset mid-conversion aborts it silently, with no done pulse.
- States: IDLE, NORM.
- IDLE, start=1 at an edge (E0):
  - sign = fixin[20].
  - mag (21-bit unsigned) = |fixin|. -2^20 gives mag=0x100000.
  - cnt=0, state=NORM, busy=1.
- NORM, at each edge, in priority order:
  - mag==0: sfpout=0x000, done.
  - cnt==17: flush to zero, sfpout=0x000, done.
  - mag[20]==1: round and pack, then done.
  - Otherwise: mag<<=1, cnt++.
- Round/pack (mag normalised, leading one at bit 20):
  - sig=mag[19:16], guard=mag[15], sticky=|mag[14:0].
  - Round up if guard & (sticky | sig[0]).
  - Biased exp = 17 - cnt.
  - sig carry out (1111+1): sig=0000, exp+1.
  - cnt<=1, or exp reaches 16 after carry: saturate, sfpout={sign,4'hF,4'hF}.
  - Zero outputs always have sign=0.
- On "done": the same edge drives done=1 for exactly one cycle, busy=0, state=IDLE. sfpout holds its value until the next done or reset.
- Latency: with the leading one of |fixin| at bit p, done is high in the cycle after edge E0+(20-p)+1.
  - Zero input: E0+1.
  - Flush cases (p<=3): E0+18.
  - Maximum: 18 edges after E0.
- Back-to-back: start may be asserted in the same cycle done is high (busy=0 then). It is accepted at the next edge.
- start while busy=1 is ignored, with no queueing.
- fixin is don't-care except at the accepting edge.

Test Plan:
- fixin=0x00400 (1.0) -> sfpout=0x070, done after E0+11, busy high for 11 cycles.
- fixin=0x1FFA00 (-1.5) -> sfpout=0x178. fixin=0x7C000 (496) -> 0x0FF after E0+3. fixin=0x80000 (512) -> saturated 0x0FF. fixin=0x100000 (-2^20) -> 0x1FF.
- Rounding:
  - 0x420 (tie, even) -> 0x070.
  - 0x460 (tie, odd) -> 0x072.
  - 0x430 (above half) -> 0x071.
  - 0x7E0 (carry into exp) -> 0x080.
- Zero and underflow:
  - fixin=0 -> 0x000, done at E0+1.
  - fixin=0x00F -> 0x000, done at E0+18.
  - fixin=0x1FFFF1 (-15) -> 0x000 with sign 0.
- Handshake:
  - start pulsed during busy -> ignored, and only one done is produced.
  - start held high continuously with changing fixin -> each conversion captures fixin at its own accept edge, and the done pulses are separated by the correct latencies.
- Reset: assert rst_n=0 mid-NORM -> the next cycle shows busy=0, done=0, sfpout=0, and no done pulse follows. A new start then converts correctly.
